// File: rtl/store_buffer_if.sv
// Core-facing store/load request signals and data-memory write port of the store buffer.
// master = core/memory side, slave = the buffer itself.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_byte;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_ready;

  logic          ld_valid;
  logic          ld_byte;
  logic [AW-1:0] ld_addr;
  logic          ld_hazard;

  logic          drain_en;
  logic          empty;
  logic [CW-1:0] count;

  logic          dm_wren;
  logic          dm_wrbyte;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;

  modport master (
    output st_valid, st_byte, st_addr, st_data, ld_valid, ld_byte, ld_addr, drain_en,
    input  st_ready, ld_hazard, empty, count, dm_wren, dm_wrbyte, dm_addr, dm_din
  );

  modport slave (
    input  st_valid, st_byte, st_addr, st_data, ld_valid, ld_byte, ld_addr, drain_en,
    output st_ready, ld_hazard, empty, count, dm_wren, dm_wrbyte, dm_addr, dm_din
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: in-order FIFO of word/byte stores retiring one per cycle to data memory,
// with a load-overlap hazard check against every buffered store.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [AW:0]   WordSpan  = (AW + 1)'(3);

  logic [DEPTH-1:0] byte_q;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic full, has_data, push, pop, head_out, hazard;
  logic [AW:0]   ld_lo, ld_hi, st_lo, st_hi;
  logic [PW-1:0] offs;

  assign full     = (count_q == FullCount);
  assign has_data = (count_q != '0);
  // No bypass: a full buffer refuses a push even while popping.
  assign push     = sb.st_valid && !full && !rst;
  assign pop      = has_data && sb.drain_en && !rst;
  assign head_out = has_data && !rst;

  assign sb.st_ready = rst || !full;
  assign sb.empty    = rst || !has_data;
  assign sb.count    = rst ? '0 : count_q;
  assign sb.dm_wren  = pop;
  assign sb.dm_wrbyte = head_out ? byte_q[rd_ptr_q] : 1'b0;
  assign sb.dm_addr   = head_out ? addr_q[rd_ptr_q] : '0;
  assign sb.dm_din    = head_out ? data_q[rd_ptr_q] : '0;

  // Ranges compared in AW+1 bits so a word near the top never wraps to address 0.
  always_comb begin
    ld_lo  = {1'b0, sb.ld_addr};
    ld_hi  = ld_lo + (sb.ld_byte ? '0 : WordSpan);
    st_lo  = '0;
    st_hi  = '0;
    offs   = '0;
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs  = PW'(i) - rd_ptr_q;
      st_lo = {1'b0, addr_q[i]};
      st_hi = st_lo + (byte_q[i] ? '0 : WordSpan);
      if (({1'b0, offs} < count_q) && (st_lo <= ld_hi) && (ld_lo <= st_hi)) begin
        hazard = 1'b1;
      end
    end
  end

  assign sb.ld_hazard = sb.ld_valid && !rst && hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      byte_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        byte_q[wr_ptr_q] <= sb.st_byte;
        addr_q[wr_ptr_q] <= sb.st_addr;
        data_q[wr_ptr_q] <= sb.st_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule
